// File: rtl/undo_history_ctrl.sv
// Bounded LIFO snapshot history for the retract path; oldest entry is overwritten when full.
// Optional move counter on output steps is built only when UNDO_STEP_COUNT_EN is defined.
module undo_history_ctrl #(
    parameter int WIDTH = 134,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_none,
    output logic             busy,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic [9:0]       steps
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        OUT
    } state_e;

    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    state_e           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_none_q, rd_none_d;
    logic             busy_q, busy_d;
    logic             push_acc;
    logic             pop_done;

    assign push_acc = (state_q == IDLE) && !clear && push;
    assign pop_done = (state_q == RD) && !clear;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_none_d  = 1'b0;
        if (clear) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // a same-cycle pop is dropped in favour of the push
                    if (push) begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        if (count_q != CNT_MAX) begin
                            count_d = count_q + (AW+1)'(1);
                        end
                    end else if (pop) begin
                        if (count_q == '0) begin
                            rd_none_d = 1'b1;
                        end else begin
                            wr_ptr_d = wr_ptr_q - AW'(1);
                            count_d  = count_q - (AW+1)'(1);
                            state_d  = RD;
                        end
                    end
                end
                RD: begin
                    // wr_ptr_q already points at the newest stored slot
                    rd_data_d  = mem[wr_ptr_q];
                    rd_valid_d = 1'b1;
                    state_d    = OUT;
                end
                OUT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_none_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_none_q  <= rd_none_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc && !reset) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_none  = rd_none_q;
    assign busy     = busy_q;
    assign count    = count_q;
    assign full     = (count_q == CNT_MAX);
    assign empty    = (count_q == '0);

`ifdef UNDO_STEP_COUNT_EN
    logic [9:0] steps_q, steps_d;

    always_comb begin
        steps_d = steps_q;
        if (clear) begin
            steps_d = '0;
        end else if (push_acc) begin
            if (steps_q != 10'd1023) begin
                steps_d = steps_q + 10'd1;
            end
        end else if (pop_done) begin
            if (steps_q != '0) begin
                steps_d = steps_q - 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            steps_q <= '0;
        end else begin
            steps_q <= steps_d;
        end
    end

    assign steps = steps_q;
`else
    assign steps = '0;
`endif

endmodule
